// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit frames
// into scan codes and queues them in a show-ahead FIFO for the MMIO decoder.
module ps2_kbd_rx #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       sig_rd_kb,
   output logic [7:0] kb_rdata,
   output logic       kb_ready,
   output logic       kb_overflow,
   output logic       frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   // Synchronisers reset to the idle line level so reset never fakes an edge.
   logic clk_s1, clk_s2, clk_s3;
   logic dat_s1, dat_s2;
   logic fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_s3 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   assign fall = clk_s3 & ~clk_s2;

   state_t          state_q, state_d;
   logic [3:0]      bitcnt_q, bitcnt_d;
   logic [10:0]     shreg_q, shreg_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic            frame_ok;
   logic            err_d;
   logic [7:0]      rx_byte;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         bitcnt_q <= 4'd0;
         shreg_q  <= 11'h7ff;
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         idle_q   <= idle_d;
      end
   end

   // Frame bits shift in from the top; once the stop bit lands the register
   // reads {stop, parity, data[7:0], start}.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      idle_d   = idle_q;
      frame_ok = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            idle_d = '0;
            if (fall) begin
               if (!dat_s2) begin
                  state_d  = S_RECV;
                  bitcnt_d = 4'd1;
                  shreg_d  = {dat_s2, shreg_q[10:1]};
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RECV: begin
            if (fall) begin
               shreg_d  = {dat_s2, shreg_q[10:1]};
               idle_d   = '0;
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q == 4'd10) begin
                  state_d  = S_IDLE;
                  bitcnt_d = 4'd0;
                  if (!shreg_d[0] && (^shreg_d[9:1]) && shreg_d[10]) frame_ok = 1'b1;
                  else err_d = 1'b1;
               end
            end else if (idle_q == TW'(TIMEOUT - 1)) begin
               state_d  = S_IDLE;
               bitcnt_d = 4'd0;
               idle_d   = '0;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rx_byte = shreg_d[8:1];

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full, push, pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = sig_rd_kb & ~empty;
   // A same-cycle pop frees a slot, so a full FIFO still accepts the frame.
   assign push  = frame_ok & (~full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         kb_overflow <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
         if (frame_ok && full && !pop) kb_overflow <= 1'b1;
         frame_err <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= rx_byte;
   end

   assign kb_ready = ~empty;
   assign kb_rdata = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: bit-bangs PS/2 frames and scoreboards the scan codes
// read back through the show-ahead FIFO.
module tb_ps2_kbd_rx;

   localparam int DEPTH = 8;
   localparam int HALF  = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk, ps2_data, sig_rd_kb;
   logic [7:0] kb_rdata;
   logic       kb_ready, kb_overflow, frame_err;

   int tests = 0;
   int fails = 0;
   int err_seen = 0;
   int exp_err = 0;
   logic exp_ovf = 1'b0;
   logic err_prev = 1'b0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] d;
      logic       bad_par;
      logic       bad_stop;
   } vec_t;

   ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(100)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .sig_rd_kb(sig_rd_kb), .kb_rdata(kb_rdata), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (frame_err) begin
         err_seen++;
         check("frame_err_width", {31'd0, err_prev}, 32'd0);
      end
      err_prev = frame_err;
   end

   // Drives bits lo..hi of frame f; optionally pops in the cycle of the stop-bit fall.
   task automatic send_bits(input logic [10:0] f, input int lo, input int hi,
                            input logic pop_at_stop, output int rdy_lat);
      rdy_lat = -1;
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            for (int c = 1; c <= HALF; c++) begin
               @(negedge clk);
               if (pop_at_stop && c == 2) begin
                  check("sim_pop_head", {24'd0, kb_rdata}, {24'd0, exp_q.pop_front()});
                  sig_rd_kb = 1'b1;
               end
               if (pop_at_stop && c == 3) sig_rd_kb = 1'b0;
               if (rdy_lat < 0 && kb_ready) rdy_lat = c;
            end
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                             input logic bad_start, input int nbits, input logic pop_at_stop,
                             output int rdy_lat);
      logic [10:0] f;
      f = {~bad_stop, (~^d) ^ bad_par, d, bad_start};
      send_bits(f, 0, nbits - 1, pop_at_stop, rdy_lat);
      if (bad_start) exp_err++;
      else if (nbits == 11) begin
         if (bad_par || bad_stop) exp_err++;
         else if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
         else exp_q.push_back(d);
      end
   endtask

   task automatic pop_check(input string name);
      logic [7:0] e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check({name, "_rdy"}, {31'd0, kb_ready}, 32'd0);
         check({name, "_data"}, {24'd0, kb_rdata}, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({name, "_rdy"}, {31'd0, kb_ready}, 32'd1);
         check({name, "_data"}, {24'd0, kb_rdata}, {24'd0, e});
      end
      sig_rd_kb = 1'b1;
      @(negedge clk);
      sig_rd_kb = 1'b0;
   endtask

   task automatic check_status(input string name);
      check({name, "_err"}, err_seen, exp_err);
      check({name, "_rdy"}, {31'd0, kb_ready}, {31'd0, exp_q.size() != 0});
      check({name, "_ovf"}, {31'd0, kb_overflow}, {31'd0, exp_ovf});
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      int lat;
      logic [10:0] tail;
      vecs[0] = '{8'h1C, 1'b0, 1'b0};
      vecs[1] = '{8'hF0, 1'b0, 1'b0};
      vecs[2] = '{8'h1C, 1'b1, 1'b0};
      vecs[3] = '{8'h32, 1'b0, 1'b0};
      vecs[4] = '{8'h55, 1'b0, 1'b1};
      vecs[5] = '{8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 1'b0, 1'b0};
      vecs[7] = '{8'hA5, 1'b1, 1'b1};

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; sig_rd_kb = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata", {24'd0, kb_rdata}, 32'd0);
      check("rst_ready", {31'd0, kb_ready}, 32'd0);
      check("rst_ovf", {31'd0, kb_overflow}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Table of frames, then drain in order.
      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop, 1'b0, 11, 1'b0, lat);
         if (i == 0) check("ready_latency_ok", {31'd0, lat >= 2 && lat <= 5}, 32'd1);
         check_status($sformatf("vec%0d", i));
      end
      while (exp_q.size() > 0) pop_check("drain");
      pop_check("drain_empty");
      pop_check("pop_while_empty");

      // Idle-state fall with data high counts as a start-bit error.
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, lat);
      repeat (6) @(negedge clk);
      check_status("start_err");

      // Full FIFO with a pop coinciding with the push.
      for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      send_frame(8'h18, 1'b0, 1'b0, 1'b0, 11, 1'b1, lat);
      check_status("full_sim");
      check("full_sim_count", exp_q.size(), DEPTH);
      while (exp_q.size() > 0) pop_check("full_sim_drain");
      pop_check("full_sim_empty");

      // Two entries held, pop coinciding with the push.
      send_frame(8'h20, 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      send_frame(8'h21, 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 11, 1'b1, lat);
      check_status("two_sim");
      while (exp_q.size() > 0) pop_check("two_sim_drain");
      pop_check("two_sim_empty");

      // Partial frame followed by a stall longer than the timeout.
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 5, 1'b0, lat);
      repeat (150) @(negedge clk);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      check_status("timeout");
      pop_check("timeout_data");
      pop_check("timeout_empty");

      // Overflow: nine frames, no pops.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      check_status("overflow");
      while (exp_q.size() > 0) pop_check("ovf_drain");
      pop_check("ovf_empty");
      check("ovf_sticky", {31'd0, kb_overflow}, 32'd1);

      // Reset mid-frame with three entries queued.
      for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      check_status("pre_reset");
      send_frame(8'hE1, 1'b0, 1'b0, 1'b0, 6, 1'b0, lat);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_rdata", {24'd0, kb_rdata}, 32'd0);
      check("mid_rst_ready", {31'd0, kb_ready}, 32'd0);
      check("mid_rst_ovf", {31'd0, kb_overflow}, 32'd0);
      check("mid_rst_err", {31'd0, frame_err}, 32'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      // Remaining bits are all high: each is an idle-state fall without a start bit.
      tail = {1'b1, 1'b1, 8'hE1, 1'b0};
      send_bits(tail, 6, 10, 1'b0, lat);
      exp_err += 5;
      check_status("post_reset_tail");
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 11, 1'b0, lat);
      check_status("post_reset_frame");
      pop_check("post_reset_data");
      pop_check("post_reset_empty");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
